// File: rtl/multdiv_controller_if.sv
// Pipeline-side bundle between the D/X stage, the multdiv unit and the controller.
// Carries decode flags, unit handshake, start pulses, stall and result injection.
// master = pipeline/unit side driving inputs; slave = the controller itself.
interface multdiv_controller_if;
    // decode and squash from the D/X stage
    logic        dx_mul;
    logic        dx_div;
    logic [4:0]  dx_rd;
    logic        flush;

    // multdiv unit completion
    logic        md_ready;
    logic        md_exception;
    logic [31:0] md_result;

    // controller outputs
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic        stall;
    logic        res_valid;
    logic [4:0]  res_rd;
    logic [31:0] res_data;
    logic        timeout_err;
    logic [31:0] stall_count;

    modport master (
        output dx_mul, dx_div, dx_rd, flush,
        output md_ready, md_exception, md_result,
        input  ctrl_MULT, ctrl_DIV, stall, res_valid, res_rd, res_data,
        input  timeout_err, stall_count
    );

    modport slave (
        input  dx_mul, dx_div, dx_rd, flush,
        input  md_ready, md_exception, md_result,
        output ctrl_MULT, ctrl_DIV, stall, res_valid, res_rd, res_data,
        output timeout_err, stall_count
    );
endinterface

// File: rtl/multdiv_controller.sv
// Sequences the multi-cycle mul/div unit: start pulse, front-end stall, result injection.
// Latency: start and stall in the detect cycle; result one cycle after md_ready.
// Backpressure: holds stall until md_ready, flush or timeout; flush releases stall at once.
module multdiv_controller #(
    parameter int unsigned TIMEOUT      = 40,
    parameter int unsigned RSTATUS_REG  = 30,
    parameter int unsigned MUL_EXC_CODE = 4,
    parameter int unsigned DIV_EXC_CODE = 5
) (
    input  logic              clock,
    input  logic              reset,
    multdiv_controller_if.slave md
);

    // Counter value seen in the last BUSY cycle before abort: the counter is
    // zero in the first BUSY cycle, so TIMEOUT BUSY cycles end at TIMEOUT-1.
    localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT - 1);
    localparam logic [4:0]  EXC_RD   = 5'(RSTATUS_REG);
    localparam logic [31:0] MUL_EXC  = 32'(MUL_EXC_CODE);
    localparam logic [31:0] DIV_EXC  = 32'(DIV_EXC_CODE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        op_mul_q;      // latched op kind: 1 = multiply, 0 = divide
    logic [4:0]  rd_q;          // latched destination register
    logic [7:0]  tmo_cnt;       // cycles spent in BUSY

    logic        res_valid_q;
    logic [4:0]  res_rd_q;
    logic [31:0] res_data_q;
    logic        timeout_err_q;
    logic [31:0] stall_cnt_q;

    // decoded control for the current cycle
    logic        start_mul;
    logic        start_div;
    logic        stall_c;
    logic        launch;
    logic        capture;
    logic        tmo_hit;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-cycle control decode
    always_comb begin
        state_nxt = state;
        start_mul = 1'b0;
        start_div = 1'b0;
        stall_c   = 1'b0;
        launch    = 1'b0;
        capture   = 1'b0;
        tmo_hit   = 1'b0;
        case (state)
            IDLE: begin
                // md_ready is deliberately not looked at here, so a result
                // from an operation abandoned by reset or flush is dropped.
                if ((md.dx_mul || md.dx_div) && !md.flush) begin
                    start_mul = md.dx_mul;
                    start_div = md.dx_div && !md.dx_mul;
                    stall_c   = 1'b1;
                    launch    = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                // flush beats both completion and timeout
                if (md.flush) begin
                    state_nxt = IDLE;
                end else begin
                    stall_c = 1'b1;
                    if (md.md_ready) begin
                        capture   = 1'b1;
                        state_nxt = DONE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        tmo_hit   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            DONE: begin
                // the finished instruction is still in D/X, so its decode
                // flags must not start a second operation
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operation context: op kind, destination and BUSY cycle counter
    always_ff @(posedge clock) begin
        if (reset) begin
            op_mul_q <= 1'b0;
            rd_q     <= 5'd0;
            tmo_cnt  <= 8'd0;
        end else if (launch) begin
            op_mul_q <= md.dx_mul;
            rd_q     <= md.dx_rd;
            tmo_cnt  <= 8'd0;
        end else if (state == BUSY) begin
            tmo_cnt  <= tmo_cnt + 8'd1;
        end
    end

    // Result register: redirect exceptions to rstatus with the per-op code
    always_ff @(posedge clock) begin
        if (reset) begin
            res_valid_q <= 1'b0;
            res_rd_q    <= 5'd0;
            res_data_q  <= 32'd0;
        end else begin
            res_valid_q <= capture;
            if (capture) begin
                if (md.md_exception) begin
                    res_rd_q   <= EXC_RD;
                    res_data_q <= op_mul_q ? MUL_EXC : DIV_EXC;
                end else begin
                    res_rd_q   <= rd_q;
                    res_data_q <= md.md_result;
                end
            end
        end
    end

    // Sticky timeout flag, cleared only by reset
    always_ff @(posedge clock) begin
        if (reset) begin
            timeout_err_q <= 1'b0;
        end else if (tmo_hit) begin
            timeout_err_q <= 1'b1;
        end
    end

    // Saturating count of cycles in which the front end was stalled
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
        end else if (stall_c && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    // Combinational outputs are held low while reset is asserted so the
    // pipeline sees no stray start or stall during a mid-operation reset.
    assign md.ctrl_MULT   = start_mul && !reset;
    assign md.ctrl_DIV    = start_div && !reset;
    assign md.stall       = stall_c && !reset;
    assign md.res_valid   = res_valid_q && !md.flush && !reset;
    assign md.res_rd      = res_rd_q;
    assign md.res_data    = res_data_q;
    assign md.timeout_err = timeout_err_q;
    assign md.stall_count = stall_cnt_q;

endmodule

// File: doc/multdiv_controller.md
# multdiv_controller

Sequences the multi-cycle multiply/divide unit for the five-stage pipeline. It watches the mul/div decode flags of the instruction in the D/X stage and issues a one-cycle start pulse to the multdiv unit. It stalls the front of the pipeline until the unit reports ready, then hands the result to the X/M latch for one cycle. Divide-by-zero and multiply overflow are redirected to the rstatus register, and the block also handles squash, timeout and a stall-cycle performance counter.

## Interface
- TIMEOUT, 40: maximum BUSY cycles allowed before abort; legal range 2..255.
- RSTATUS_REG, 30: register index written on exception.
- MUL_EXC_CODE, 4: rstatus value written on multiply overflow.
- DIV_EXC_CODE, 5: rstatus value written on divide exception.

- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- dx_mul  in  1  decoded mul flag for the instruction in D/X.
- dx_div  in  1  decoded div flag for the instruction in D/X.
- dx_rd  in  5  destination register of the D/X instruction.
- flush  in  1  squash of D/X from a taken branch/jump.
- md_ready  in  1  multdiv unit result valid; may be a pulse or a level.
- md_exception  in  1  exception flag; qualified by md_ready.
- md_result  in  32  multdiv result; qualified by md_ready.
- ctrl_MULT  out  1  single-cycle multiply start (combinational).
- ctrl_DIV  out  1  single-cycle divide start (combinational).
- stall  out  1  freeze PC, F/D and D/X (combinational).
- res_valid  out  1  inject result into X/M this cycle (registered).
- res_rd  out  5  destination register for the injected result (registered).
- res_data  out  32  injected result value (registered).
- timeout_err  out  1  sticky; set on timeout abort.
- stall_count  out  32  saturating count of stall cycles.

## Operation
- The FSM has three states: IDLE, BUSY and DONE. Reset forces IDLE.
- Reset values: every output is 0, including stall_count and timeout_err.
- **IDLE**
  - Operation detected: op = dx_mul | dx_div, and flush = 0.
  - On detection: ctrl_MULT = dx_mul, ctrl_DIV = dx_div & ~dx_mul (mul has priority if both are set), stall = 1.
  - On detection, latch dx_rd and the op kind, clear the timeout counter, and go to BUSY.
  - If flush = 1, no start is issued and the state stays IDLE.
  - md_ready is ignored in IDLE.
- **BUSY**
  - stall = 1 every cycle; the timeout counter increments each cycle.
  - md_ready = 1: capture the result and go to DONE.
    - Normal result: res_data = md_result, res_rd = latched rd.
    - md_exception = 1: res_rd = RSTATUS_REG, res_data = MUL_EXC_CODE or DIV_EXC_CODE by latched op, zero-extended.
  - flush = 1: go to IDLE, discard any result, and drop stall the same cycle (combinational). flush has priority over md_ready.
  - Timeout: the counter reaching TIMEOUT with no md_ready → go to IDLE, set timeout_err, no result.
- **DONE**
  - res_valid = 1 and stall = 0, so the mul/div instruction advances to X/M in this cycle.
  - Always returns to IDLE next cycle.
  - dx_mul/dx_div are ignored in DONE, because the same instruction is still in D/X.
  - flush = 1 in DONE forces res_valid = 0.
- **Other rules**
  - stall_count increments in every cycle with stall = 1 and saturates at 0xFFFFFFFF.
  - timeout_err clears only on reset.
  - Reset mid-operation returns to IDLE. The unit's in-flight result is then ignored, because md_ready is not sampled in IDLE.

## Timing
- Start: op detected in IDLE at cycle T0 → ctrl pulse and stall at T0, BUSY from T1.
- Completion: md_ready at cycle Tk (k ≥ 1) → DONE at Tk+1, with res_valid high for exactly one cycle.
- Stall duration: stall is high from T0 through Tk inclusive, i.e. k+1 cycles.
- Fastest case: md_ready at T1 → 2 stall cycles, result at T2.
- Timeout: with no md_ready, stall is high T0..T(TIMEOUT); timeout_err rises at T(TIMEOUT+1) along with IDLE.
- Back-to-back: after DONE at cycle Td, a following mul in D/X is detected at Td+1. The minimum start-to-start spacing is k+2 cycles.
- Start pulses: ctrl_MULT/ctrl_DIV are never high for two consecutive cycles.

## Test plan
- Basic mul:
  - Stimulus: dx_mul=1, dx_rd=7 at T0; md_ready=1, md_result=0x0000_0024 at T5.
  - Required: ctrl_MULT high at T0 only; stall high T0–T5; res_valid=1, res_rd=7, res_data=0x24 at T6; stall_count=6.
- Divide by zero:
  - Stimulus: dx_div=1, rd=3; md_ready=1 with md_exception=1 at T33.
  - Required: at T34 res_rd=30, res_data=5, res_valid=1.
  - Repeat with mul and overflow: required res_data=4.
- Flush:
  - Flush in BUSY at T3 → stall low at T3, IDLE at T4; a later md_ready at T6 produces no res_valid.
  - Flush in IDLE with dx_mul=1 → no ctrl pulse, no stall.
- Timeout:
  - Stimulus: TIMEOUT=8, md_ready held low.
  - Required: stall high T0–T8; timeout_err=1 from T9 and stays set; next mul starts normally.
- Reset mid-BUSY:
  - Stimulus: reset at T2, md_ready at T4.
  - Required: IDLE at T3, all outputs 0, no res_valid at T5.
- Edge cases:
  - Back-to-back mul→div: second start exactly at Td+1; no start while in DONE.
  - dx_mul and dx_div both set: only ctrl_MULT pulses.
